// File: rtl/ysyx_arb_pkg.sv
// Shared types and default widths for the IFU/LSU data-memory arbiter.
package ysyx_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } arb_owner_t;

endpackage

// File: rtl/ysyx_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// Define YSYX_ARB_RR_EN for round-robin ties; otherwise LSU has fixed priority.
module ysyx_arb_pick
  import ysyx_arb_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
`ifdef YSYX_ARB_RR_EN
  input  arb_owner_t last_owner_i,
`endif
  output logic       gnt_ifu_o,
  output logic       gnt_lsu_o
);

`ifdef YSYX_ARB_RR_EN
  logic tie;
  assign tie = ifu_valid_i && lsu_valid_i;

  // On a tie the requester that did not win last time goes first.
  assign gnt_ifu_o = tie ? (last_owner_i == OWN_LSU) : ifu_valid_i;
  assign gnt_lsu_o = tie ? (last_owner_i == OWN_IFU) : lsu_valid_i;
`else
  assign gnt_lsu_o = lsu_valid_i;
  assign gnt_ifu_o = ifu_valid_i && !lsu_valid_i;
`endif

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one data-memory port between IFU and LSU, one transaction in flight.
// YSYX_ARB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
module ysyx_mem_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [ARB_MASK_W-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [ARB_MASK_W-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t            state_q;
  arb_owner_t            owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [ARB_MASK_W-1:0] wmask_q;

  logic gnt_ifu, gnt_lsu;
  logic ifu_accept, lsu_accept, resp_fire;

  // owner_q resets to LSU and is rewritten on every acceptance, so it also
  // serves as the round-robin history.
  ysyx_arb_pick u_pick (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
`ifdef YSYX_ARB_RR_EN
    .last_owner_i (owner_q),
`endif
    .gnt_ifu_o    (gnt_ifu),
    .gnt_lsu_o    (gnt_lsu)
  );

  assign ifu_req_ready = (state_q == IDLE) && gnt_ifu;
  assign lsu_req_ready = (state_q == IDLE) && gnt_lsu;
  assign ifu_accept    = ifu_req_valid && ifu_req_ready;
  assign lsu_accept    = lsu_req_valid && lsu_req_ready;

  // NOTE: every register here uses <= so all of them sample the same pre-edge
  // values; blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_accept) begin
            owner_q <= OWN_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
            state_q <= REQ;
          end else if (ifu_accept) begin
            owner_q <= OWN_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            state_q <= REQ;
          end
        end
        REQ:     if (mem_req_ready)  state_q <= WAIT;
        WAIT:    if (mem_resp_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Responses outside WAIT are stray and never reach a requester.
  assign resp_fire      = (state_q == WAIT) && mem_resp_valid;
  assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

endmodule
